// File: rtl/sdram_host_pkg.sv
// Shared types and helpers for the SDRAM host sequencer: FSM encoding, byte-lane
// selection and refresh-interval arithmetic.
package sdram_host_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RF_ACK,
    ST_RF_WAIT,
    ST_RD_ACK,
    ST_RD_WAIT,
    ST_MERGE,
    ST_WR_ACK,
    ST_WR_WAIT,
    ST_DONE
  } state_t;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  // 7.8 us expressed in clk cycles (clk = 2x SDRAM clock), less a 2-cycle margin.
  function automatic int refresh_period(input int freq_mhz);
    return (7800 * freq_mhz / 1000) * 2 - 2;
  endfunction

  function automatic logic [7:0] lane_select(input logic [15:0] word, input logic lane);
    return (lane == LANE_HI) ? word[15:8] : word[7:0];
  endfunction

  function automatic logic [15:0] lane_merge(input logic [15:0] word, input logic lane,
                                             input logic [7:0] data);
    return (lane == LANE_HI) ? {data, word[7:0]} : {word[15:8], data};
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval timer: counts clken cycles, raises a pending flag every period.
// Latency: pending sets on the wrap edge; a wrap while still pending sets the sticky miss flag.
module sdram_refresh_timer #(
  parameter int REFRESH_PERIOD = 998
) (
  input  logic clk,
  input  logic reset,
  input  logic clken,
  input  logic clear,
  output logic pending,
  output logic miss
);

  localparam int CW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_PERIOD - 1);

  logic [CW-1:0] count;
  logic          wrap;

  assign wrap = clken && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      pending <= 1'b0;
      miss    <= 1'b0;
    end else begin
      if (clken) begin
        count <= wrap ? '0 : count + CW'(1);
      end
      // A new period owes a refresh even if the previous one is being serviced now.
      if (wrap) begin
        pending <= 1'b1;
      end else if (clear) begin
        pending <= 1'b0;
      end
      if (wrap && pending) begin
        miss <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_host_sequencer.sv
// Byte-wide CPU to 16-bit SDRAM host-port sequencer with periodic refresh (refresh wins in IDLE).
// Latency: read = ctrl op + 3 clk, write (RMW) = 2 ctrl ops + 6 clk; cpu_busy holds the CPU off.
module sdram_host_sequencer
  import sdram_host_pkg::*;
#(
  parameter int FREQCLKSDRAM   = 64,
  parameter int REFRESH_PERIOD = 998
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clken,
  input  logic [24:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_busy,
  output logic [23:0] mem_addr,
  output logic        mem_read_rq,
  output logic        mem_write_rq,
  output logic        mem_rfsh_rq,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_busy,
  output logic        rfsh_miss
);

  localparam int MAX_PERIOD = refresh_period(FREQCLKSDRAM) + 2;

  if (REFRESH_PERIOD > MAX_PERIOD) begin : g_period_check
    $error("REFRESH_PERIOD longer than the 7.8 us refresh interval");
  end

  state_t state, state_nxt;

  logic        rfsh_pending;
  logic        rfsh_clear;
  logic        op_wr;
  logic        lane;
  logic [7:0]  wdata;
  logic [15:0] word;

  logic read_rq_nxt, write_rq_nxt, rfsh_rq_nxt;
  logic ack_nxt, busy_nxt;
  logic accept, rd_done, merge;

  sdram_refresh_timer #(
    .REFRESH_PERIOD (REFRESH_PERIOD)
  ) u_refresh_timer (
    .clk     (clk),
    .reset   (reset),
    .clken   (clken),
    .clear   (rfsh_clear),
    .pending (rfsh_pending),
    .miss    (rfsh_miss)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    read_rq_nxt  = mem_read_rq;
    write_rq_nxt = mem_write_rq;
    rfsh_rq_nxt  = mem_rfsh_rq;
    ack_nxt      = 1'b0;
    busy_nxt     = cpu_busy;
    rfsh_clear   = 1'b0;
    accept       = 1'b0;
    rd_done      = 1'b0;
    merge        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!mem_busy) begin
          if (rfsh_pending) begin
            rfsh_rq_nxt = 1'b1;
            rfsh_clear  = 1'b1;
            state_nxt   = ST_RF_ACK;
          end else if (cpu_rd || cpu_wr) begin
            // Writes start with a read too: the controller always writes both lanes.
            accept      = 1'b1;
            read_rq_nxt = 1'b1;
            busy_nxt    = 1'b1;
            state_nxt   = ST_RD_ACK;
          end
        end
      end
      ST_RF_ACK: begin
        if (mem_busy) begin
          rfsh_rq_nxt = 1'b0;
          state_nxt   = ST_RF_WAIT;
        end
      end
      ST_RF_WAIT: begin
        if (!mem_busy) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RD_ACK: begin
        if (mem_busy) begin
          read_rq_nxt = 1'b0;
          state_nxt   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (!mem_busy) begin
          rd_done = 1'b1;
          if (op_wr) begin
            state_nxt = ST_MERGE;
          end else begin
            ack_nxt   = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_MERGE: begin
        if (!mem_busy) begin
          merge        = 1'b1;
          write_rq_nxt = 1'b1;
          state_nxt    = ST_WR_ACK;
        end
      end
      ST_WR_ACK: begin
        if (mem_busy) begin
          write_rq_nxt = 1'b0;
          state_nxt    = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (!mem_busy) begin
          ack_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_rq  <= 1'b0;
      mem_write_rq <= 1'b0;
      mem_rfsh_rq  <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      cpu_ack      <= 1'b0;
      cpu_busy     <= 1'b0;
      cpu_dout     <= '0;
      op_wr        <= 1'b0;
      lane         <= LANE_LO;
      wdata        <= '0;
      word         <= '0;
    end else begin
      mem_read_rq  <= read_rq_nxt;
      mem_write_rq <= write_rq_nxt;
      mem_rfsh_rq  <= rfsh_rq_nxt;
      cpu_ack      <= ack_nxt;
      cpu_busy     <= busy_nxt;
      if (accept) begin
        mem_addr <= cpu_addr[24:1];
        lane     <= cpu_addr[0];
        wdata    <= cpu_din;
        op_wr    <= !cpu_rd;
      end
      if (rd_done) begin
        word <= mem_dout;
        if (!op_wr) begin
          cpu_dout <= lane_select(mem_dout, lane);
        end
      end
      if (merge) begin
        mem_din <= lane_merge(word, lane, wdata);
      end
    end
  end

endmodule

// File: tb/tb_sdram_host_sequencer.sv
// Scoreboard bench: byte-level reference memory predicts CPU results; a behavioural
// controller model with a word store answers the host port with random busy times.
module tb_sdram_host_sequencer;

  localparam int RP   = 16;
  localparam int OP_F = 1;
  localparam int OP_R = 2;
  localparam int OP_W = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clken = 1'b0;
  logic [24:0] cpu_addr = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        cpu_busy;
  logic [23:0] mem_addr;
  logic        mem_read_rq;
  logic        mem_write_rq;
  logic        mem_rfsh_rq;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = '0;
  logic        mem_busy;
  logic        rfsh_miss;

  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  logic stall = 1'b0;
  assign mem_busy = force_busy | model_busy;

  sdram_host_sequencer #(
    .FREQCLKSDRAM   (64),
    .REFRESH_PERIOD (RP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clken        (clken),
    .cpu_addr     (cpu_addr),
    .cpu_rd       (cpu_rd),
    .cpu_wr       (cpu_wr),
    .cpu_din      (cpu_din),
    .cpu_dout     (cpu_dout),
    .cpu_ack      (cpu_ack),
    .cpu_busy     (cpu_busy),
    .mem_addr     (mem_addr),
    .mem_read_rq  (mem_read_rq),
    .mem_write_rq (mem_write_rq),
    .mem_rfsh_rq  (mem_rfsh_rq),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    .mem_busy     (mem_busy),
    .rfsh_miss    (rfsh_miss)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit         is_wr;
    int         addr;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          op_log[$];
  logic [15:0] wmem[int];
  logic [7:0]  ref_mem[int];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  function automatic logic [15:0] init_word(input int wa);
    return 16'(wa * 40503) ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] ctl_word(input int wa);
    return wmem.exists(wa) ? wmem[wa] : init_word(wa);
  endfunction

  function automatic logic [7:0] ref_byte(input int a);
    logic [15:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word(a / 2);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  function automatic int log_code(input bit skip_rf);
    int i;
    int g;
    i = 0;
    g = 0;
    if (skip_rf) while (i < op_log.size() && op_log[i] == OP_F) i++;
    for (int j = i; j < op_log.size(); j++) g = g * 16 + op_log[j];
    return g;
  endfunction

  // Controller model: accepts one request when idle, stays busy 1..5 clk.
  initial begin
    int          cnt;
    logic        rd_pend;
    logic [15:0] rd_word;
    cnt = 0;
    rd_pend = 1'b0;
    rd_word = '0;
    forever begin
      @(posedge clk);
      #1;
      if (model_busy) begin
        cnt--;
        if (cnt == 0) begin
          model_busy = 1'b0;
          if (rd_pend) mem_dout = rd_word;
          rd_pend = 1'b0;
        end
      end else if (!stall && !force_busy && (mem_read_rq || mem_write_rq || mem_rfsh_rq)) begin
        check("single_rq", 32'(mem_read_rq) + 32'(mem_write_rq) + 32'(mem_rfsh_rq), 1);
        model_busy = 1'b1;
        cnt = $urandom_range(1, 5);
        mem_dout = 16'($urandom);
        if (mem_rfsh_rq) op_log.push_back(OP_F);
        if (mem_read_rq) begin
          op_log.push_back(OP_R);
          rd_pend = 1'b1;
          rd_word = ctl_word(int'(mem_addr));
        end
        if (mem_write_rq) begin
          op_log.push_back(OP_W);
          wmem[int'(mem_addr)] = mem_din;
        end
      end
    end
  end

  // Monitor: every cpu_ack consumes one expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_ack) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ack: cpu_ack=1 with no outstanding request");
        end else begin
          e = exp_q.pop_front();
          check("ack_busy_low", 32'(cpu_busy), 0);
          check("mem_addr", 32'(mem_addr), e.addr / 2);
          if (!e.is_wr) check("read_data", 32'(cpu_dout), 32'(e.data));
          else check("write_word", 32'(ctl_word(e.addr / 2)),
                     32'({ref_byte(e.addr | 1), ref_byte(e.addr & ~1)}));
        end
      end
    end
  end

  task automatic start_access(input bit rd, input bit wr, input logic [24:0] a, input logic [7:0] d);
    exp_t e;
    e.is_wr = !rd;
    e.addr  = int'(a);
    e.data  = rd ? ref_byte(int'(a)) : d;
    if (!rd) ref_mem[int'(a)] = d;
    exp_q.push_back(e);
    op_log.delete();
    cpu_addr = a;
    cpu_din  = d;
    cpu_rd   = rd;
    cpu_wr   = wr;
  endtask

  task automatic wait_ack(input bit is_wr);
    int k;
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      if (cpu_ack) break;
      k++;
    end
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    if (k >= 2000) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout: no cpu_ack within 2000 clk");
      exp_q.delete();
    end else begin
      check("op_sequence", log_code(1'b1), is_wr ? (OP_R * 16 + OP_W) : OP_R);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (mem_busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ctrl_idle", 32'(mem_busy), 0);
  endtask

  task automatic guard_window(input int n);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (mem_read_rq || mem_write_rq || mem_rfsh_rq || cpu_busy) seen = 1'b1;
    end
    check("guard_no_rq", 32'(seen), 0);
    force_busy = 1'b0;
    @(negedge clk);
    check("launch_after_busy_low", 32'(mem_read_rq), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read_rq"}, 32'(mem_read_rq), 0);
    check({tag, "_write_rq"}, 32'(mem_write_rq), 0);
    check({tag, "_rfsh_rq"}, 32'(mem_rfsh_rq), 0);
    check({tag, "_cpu_ack"}, 32'(cpu_ack), 0);
    check({tag, "_cpu_busy"}, 32'(cpu_busy), 0);
    check({tag, "_rfsh_miss"}, 32'(rfsh_miss), 0);
    check({tag, "_cpu_dout"}, 32'(cpu_dout), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_din"}, 32'(mem_din), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] bases[4];
    logic [24:0] a;
    logic [7:0]  old;
    int          r;
    int          k;

    bases = '{25'h0000000, 25'h1FFFFC0, 25'h0ABCD00, 25'h1234560};

    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Controller still initialising: a pending read must wait for mem_busy=0.
    force_busy = 1'b1;
    reset = 1'b0;
    start_access(1'b1, 1'b0, 25'h0000101, 8'h00);
    guard_window(200);
    wait_ack(1'b0);
    clken = 1'b1;

    wmem[24'h10] = 16'h1234;
    ref_mem[32'h20] = 8'h34;
    ref_mem[32'h21] = 8'h12;
    start_access(1'b1, 1'b0, 25'h0000021, 8'h00);
    wait_ack(1'b0);
    check("byte_read", 32'(cpu_dout), 32'h12);

    wmem[24'h05] = 16'hAABB;
    ref_mem[32'h0A] = 8'hBB;
    ref_mem[32'h0B] = 8'hAA;
    start_access(1'b0, 1'b1, 25'h000000A, 8'h55);
    wait_ack(1'b1);
    check("rmw_word", 32'(ctl_word(5)), 32'hAA55);
    check("rmw_mem_din", 32'(mem_din), 32'hAA55);

    // Read request arrives in the cycle the refresh becomes pending.
    wait_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (RP) @(posedge clk);
    @(negedge clk);
    start_access(1'b1, 1'b0, 25'h0000021, 8'h00);
    wait_ack(1'b0);
    check("refresh_first", log_code(1'b0), OP_F * 16 + OP_R);

    wait_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("miss_clear", 32'(rfsh_miss), 0);
    force_busy = 1'b1;
    repeat (40) @(negedge clk);
    check("miss_set", 32'(rfsh_miss), 1);
    force_busy = 1'b0;

    for (int i = 0; i < 250; i++) begin
      clken = ($urandom_range(0, 3) != 0);
      a = bases[$urandom_range(0, 3)] + 25'($urandom_range(0, 31));
      r = $urandom_range(0, 9);
      if (r < 5) begin
        start_access(1'b1, 1'b0, a, 8'($urandom));
        wait_ack(1'b0);
      end else if (r < 9) begin
        start_access(1'b0, 1'b1, a, 8'($urandom));
        wait_ack(1'b1);
      end else begin
        start_access(1'b1, 1'b1, a, 8'($urandom));
        wait_ack(1'b0);
      end
      @(negedge clk);
    end
    check("miss_sticky", 32'(rfsh_miss), 1);
    clken = 1'b1;

    // Reset while the write half of an RMW waits for the controller.
    wait_idle();
    a = 25'h000000C;
    old = ref_byte(int'(a));
    start_access(1'b0, 1'b1, a, 8'h77);
    k = 0;
    while (!(op_log.size() > 0 && op_log[op_log.size() - 1] == OP_R) && k < 200) begin
      @(negedge clk);
      k++;
    end
    stall = 1'b1;
    k = 0;
    while (!mem_write_rq && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reached_wr_ack", 32'(mem_write_rq), 1);
    reset = 1'b1;
    cpu_wr = 1'b0;
    @(negedge clk);
    check("rst_read_rq", 32'(mem_read_rq), 0);
    check("rst_write_rq", 32'(mem_write_rq), 0);
    check("rst_rfsh_rq", 32'(mem_rfsh_rq), 0);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_cpu_busy", 32'(cpu_busy), 0);
    check("rst_rfsh_miss", 32'(rfsh_miss), 0);
    exp_q.delete();
    ref_mem[int'(a)] = old;
    stall = 1'b0;
    clken = 1'b0;
    force_busy = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start_access(1'b1, 1'b0, a, 8'h00);
    guard_window(20);
    wait_ack(1'b0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
